// File: rtl/spi_pkg.sv
// Shared types and constants for the motor-command SPI transmitter.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } spi_tx_state_t;

endpackage

// File: rtl/spi_motor_tx_if.sv
// Command handshake plus SPI lines between a frame requester and spi_motor_tx.
interface spi_motor_tx_if;

    logic       start;
    logic [7:0] motor1;
    logic [7:0] motor2;
    logic       busy;
    logic       done;
    logic       sck;
    logic       load;
    logic       sdo;

    modport master (
        output start, motor1, motor2,
        input  busy, done, sck, load, sdo
    );

    modport slave (
        input  start, motor1, motor2,
        output busy, done, sck, load, sdo
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period divider: tick is high on the last of every CLK_DIV cycles since clear.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/spi_motor_tx.sv
// Controller-side SPI mode-0 transmitter for one 16-bit {motor1, motor2} frame per start,
// framed by active-low load with a half-period hold and gap around each frame.
module spi_motor_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    spi_motor_tx_if.slave bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    spi_tx_state_t         state;
    spi_tx_state_t         next_state;
    logic                  tick;
    logic                  state_change;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_d;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    logic                  sck_q, sck_d;
    logic                  load_q, load_d;
    logic                  sdo_q, sdo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign state_change = (next_state != state);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_change),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
            load_q  <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= next_state;
            bit_cnt <= bit_cnt_d;
            sck_q   <= sck_d;
            load_q  <= load_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
        // NOTE: the shift register is pure datapath, reloaded on every accepted start, so it needs no reset.
        shreg <= shreg_d;
    end

    // Every non-idle state advances exactly on its divider tick.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = LOW;
            LOW:     if (tick) next_state = HIGH;
            HIGH:    if (tick) next_state = (bit_cnt == LAST_BIT) ? HOLD : LOW;
            HOLD:    if (tick) next_state = GAP;
            GAP:     if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        sck_d     = sck_q;
        load_d    = load_q;
        sdo_d     = sdo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_d   = {bus.motor1, bus.motor2};
                    sdo_d     = bus.motor1[7];
                    load_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            LOW: begin
                if (tick) sck_d = 1'b1;
            end
            HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    // sdo moves on the falling edge, a full half-period before the next rise.
                    if (bit_cnt != LAST_BIT) begin
                        shreg_d   = shreg << 1;
                        sdo_d     = shreg[FRAME_BITS-2];
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    load_d = 1'b1;
                    sdo_d  = 1'b0;
                end
            end
            GAP: begin
                if (tick) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.sck  = sck_q;
    assign bus.load = load_q;
    assign bus.sdo  = sdo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_motor_tx.sv
// Three transmitters (CLK_DIV 4, 1, 7) each observed by a behavioural mode-0 SPI receiver.
module tb_spi_motor_tx;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      rst_s;
    logic [N-1:0]      start_s;
    logic [N-1:0][7:0] m1_s;
    logic [N-1:0][7:0] m2_s;
    logic [N-1:0]      sck_o, load_o, sdo_o, busy_o, done_o;

    int checks   = 0;
    int failures = 0;

    function automatic int div_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : (g == 1) ? 1 : 7;
        spi_motor_tx_if bus ();
        assign bus.start  = start_s[g];
        assign bus.motor1 = m1_s[g];
        assign bus.motor2 = m2_s[g];
        assign sck_o[g]   = bus.sck;
        assign load_o[g]  = bus.load;
        assign sdo_o[g]   = bus.sdo;
        assign busy_o[g]  = bus.busy;
        assign done_o[g]  = bus.done;
        spi_motor_tx #(.CLK_DIV(DIV)) dut (
            .clk  (clk),
            .reset(rst_s[g]),
            .bus  (bus.slave)
        );
    end

    // Receiver / line monitor state, one slot per transmitter.
    bit [15:0] rx[N], last_frame[N];
    int rises[N], frames[N], last_rises[N], last_ll[N], last_gap[N];
    int ll_run[N], gap_run[N], hi_run[N], lo_run[N];
    int width_err[N], sdo_err[N], done_cnt[N], done_err[N];
    bit hi_valid[N], lo_valid[N], gap_valid[N], fr_valid[N];
    bit p_sck[N], p_load[N], p_sdo[N], p_done[N];

    // Sampled at posedge: reads the values held during the preceding cycle.
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (done_o[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                if (p_done[g]) done_err[g] <= done_err[g] + 1;
            end
            if (rst_s[g]) begin
                hi_valid[g]  <= 1'b0;
                lo_valid[g]  <= 1'b0;
                gap_valid[g] <= 1'b0;
                fr_valid[g]  <= 1'b0;
            end else begin
                if (sck_o[g] && !p_sck[g]) begin
                    if (!load_o[g]) begin
                        rx[g]    <= {rx[g][14:0], sdo_o[g]};
                        rises[g] <= rises[g] + 1;
                    end
                    if (lo_valid[g] && lo_run[g] != div_of(g)) width_err[g] <= width_err[g] + 1;
                    hi_run[g]   <= 1;
                    hi_valid[g] <= 1'b1;
                end else if (!sck_o[g] && p_sck[g]) begin
                    if (hi_valid[g] && hi_run[g] != div_of(g)) width_err[g] <= width_err[g] + 1;
                    lo_run[g]   <= 1;
                    lo_valid[g] <= !load_o[g];
                end else if (sck_o[g]) begin
                    hi_run[g] <= hi_run[g] + 1;
                end else begin
                    lo_run[g] <= lo_run[g] + 1;
                end
                if (sck_o[g] && p_sck[g] && sdo_o[g] != p_sdo[g]) sdo_err[g] <= sdo_err[g] + 1;
                if (!load_o[g] && p_load[g]) begin
                    rx[g]       <= '0;
                    rises[g]    <= 0;
                    ll_run[g]   <= 1;
                    fr_valid[g] <= 1'b1;
                    if (gap_valid[g]) last_gap[g] <= gap_run[g];
                end else if (load_o[g] && !p_load[g]) begin
                    last_ll[g]    <= ll_run[g];
                    last_rises[g] <= rises[g];
                    if (fr_valid[g] && rises[g] == 16) begin
                        frames[g]     <= frames[g] + 1;
                        last_frame[g] <= rx[g];
                    end
                    gap_run[g]   <= 1;
                    gap_valid[g] <= 1'b1;
                    lo_valid[g]  <= 1'b0;
                end else if (load_o[g]) begin
                    gap_run[g] <= gap_run[g] + 1;
                end else begin
                    ll_run[g] <= ll_run[g] + 1;
                end
            end
            p_sck[g]  <= sck_o[g];
            p_load[g] <= load_o[g];
            p_sdo[g]  <= sdo_o[g];
            p_done[g] <= done_o[g];
        end
    end

    task automatic wait_done(input int g, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_o[g]) ok = 1'b1;
        end
    endtask

    // Reference: the receiver must see {a,b}, 16 rises, load low 33*CLK_DIV cycles.
    task automatic send_frame(input int g, input logic [7:0] a, input logic [7:0] b, input string tag);
        int f0;
        bit ok;
        f0 = frames[g];
        @(negedge clk);
        m1_s[g] = a; m2_s[g] = b; start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        wait_done(g, 36 * div_of(g) + 10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_timeout g=%0d got=no_done expected=done", tag, g);
        end
        checks++;
        if (frames[g] !== f0 + 1 || last_frame[g] !== {a, b}) begin
            failures++;
            $display("FAIL %s_frame g=%0d got=%h frames=%0d expected=%h frames=%0d",
                     tag, g, last_frame[g], frames[g], {a, b}, f0 + 1);
        end
        checks++;
        if (last_rises[g] !== 16 || last_ll[g] !== 33 * div_of(g)) begin
            failures++;
            $display("FAIL %s_shape g=%0d got rises=%0d load_low=%0d expected rises=16 load_low=%0d",
                     tag, g, last_rises[g], last_ll[g], 33 * div_of(g));
        end
    endtask

    task automatic test_reset();
        rst_s = '1; start_s = '0; m1_s = '0; m2_s = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            checks++;
            if ({sck_o[g], load_o[g], sdo_o[g], busy_o[g], done_o[g]} !== 5'b01000) begin
                failures++;
                $display("FAIL reset_state g=%0d got sck/load/sdo/busy/done=%b expected=01000", g,
                         {sck_o[g], load_o[g], sdo_o[g], busy_o[g], done_o[g]});
            end
        end
        rst_s = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int low_cnt = 0, done_hits = 0, done_idx = -1;
        bit busy135 = 0, busy136 = 1, load0 = 1, sdo0 = 0;
        @(negedge clk);
        m1_s[0] = 8'hA5; m2_s[0] = 8'h3C; start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        // k counts clock edges since the accepting edge.
        for (int k = 0; k <= 140; k++) begin
            if (k == 0) begin load0 = load_o[0]; sdo0 = sdo_o[0]; end
            if (!load_o[0]) low_cnt++;
            if (done_o[0]) begin
                done_hits++;
                if (done_idx < 0) done_idx = k;
            end
            if (k == 135) busy135 = busy_o[0];
            if (k == 136) busy136 = busy_o[0];
            @(negedge clk);
        end
        checks++;
        if (load0 !== 1'b0 || sdo0 !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_bit got load=%b sdo=%b expected load=0 sdo=1", load0, sdo0);
        end
        checks++;
        if (low_cnt !== 132) begin
            failures++;
            $display("FAIL basic_load_low got=%0d expected=132", low_cnt);
        end
        checks++;
        if (done_idx !== 136 || done_hits !== 1) begin
            failures++;
            $display("FAIL basic_done got edge=%0d pulses=%0d expected edge=136 pulses=1", done_idx, done_hits);
        end
        checks++;
        if (busy135 !== 1'b1 || busy136 !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got b135=%b b136=%b expected 1 0", busy135, busy136);
        end
        checks++;
        if (last_frame[0] !== 16'hA53C || last_rises[0] !== 16) begin
            failures++;
            $display("FAIL basic_rx got=%h rises=%0d expected=a53c rises=16", last_frame[0], last_rises[0]);
        end
    endtask

    task automatic test_back_to_back();
        int dc0;
        bit ok1, ok2;
        dc0 = done_cnt[0];
        @(negedge clk);
        m1_s[0] = 8'h01; m2_s[0] = 8'h80; start_s[0] = 1'b1;
        wait_done(0, 200, ok1);
        m1_s[0] = 8'hFF; m2_s[0] = 8'h00;
        checks++;
        if (!ok1 || last_frame[0] !== 16'h0180) begin
            failures++;
            $display("FAIL b2b_first got done=%b rx=%h expected done=1 rx=0180", ok1, last_frame[0]);
        end
        wait_done(0, 200, ok2);
        start_s[0] = 1'b0;
        checks++;
        if (!ok2 || last_frame[0] !== 16'hFF00) begin
            failures++;
            $display("FAIL b2b_second got done=%b rx=%h expected done=1 rx=ff00", ok2, last_frame[0]);
        end
        checks++;
        if (last_gap[0] !== div_of(0) + 1) begin
            failures++;
            $display("FAIL b2b_gap got=%0d expected=%0d", last_gap[0], div_of(0) + 1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt[0] - dc0 !== 2 || busy_o[0] !== 1'b0 || load_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got dones=%0d busy=%b load=%b expected dones=2 busy=0 load=1",
                     done_cnt[0] - dc0, busy_o[0], load_o[0]);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] a, b;
        int f0, k;
        bit ok;
        a = 8'($urandom); b = 8'($urandom); f0 = frames[0];
        @(negedge clk);
        m1_s[0] = a; m2_s[0] = b; start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        k = 0; ok = 1'b0;
        while (k < 200 && !ok) begin
            if (done_o[0]) begin
                ok = 1'b1;
            end else begin
                if (k == 10 || k == 60) begin
                    start_s[0] = 1'b1; m1_s[0] = ~a; m2_s[0] = ~b;
                end
                if (k == 11 || k == 61) start_s[0] = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!ok || frames[0] !== f0 + 1 || last_frame[0] !== {a, b}) begin
            failures++;
            $display("FAIL ignore_frame got done=%b rx=%h frames=%0d expected done=1 rx=%h frames=%0d",
                     ok, last_frame[0], frames[0], {a, b}, f0 + 1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0 || load_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL ignore_not_queued got busy=%b load=%b expected busy=0 load=1", busy_o[0], load_o[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dc0, f0;
        dc0 = done_cnt[0]; f0 = frames[0];
        @(negedge clk);
        m1_s[0] = 8'h12; m2_s[0] = 8'h34; start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (50) @(negedge clk);
        rst_s[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({load_o[0], sck_o[0], busy_o[0], done_o[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_state got load/sck/busy/done=%b expected=1000",
                     {load_o[0], sck_o[0], busy_o[0], done_o[0]});
        end
        rst_s[0] = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt[0] !== dc0 || frames[0] !== f0 || load_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_abandon got dones=%0d frames=%0d load=%b expected dones=%0d frames=%0d load=1",
                     done_cnt[0], frames[0], load_o[0], dc0, f0);
        end
        send_frame(0, 8'h5A, 8'hC3, "midreset_new");
    endtask

    task automatic test_random();
        for (int g = 1; g < N; g++) begin
            for (int i = 0; i < 100; i++) begin
                send_frame(g, 8'($urandom), 8'($urandom), "random");
            end
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (width_err[g] !== 0 || sdo_err[g] !== 0 || done_err[g] !== 0) begin
                failures++;
                $display("FAIL line_rules g=%0d got width_err=%0d sdo_err=%0d done_err=%0d expected all 0",
                         g, width_err[g], sdo_err[g], done_err[g]);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
